// File: rtl/stage_2_pkg.sv
// Shared constants, formats and the ID/EX record for the RV32I decode stage.
// Imported by the decode stage and its register file.
package stage_2_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [XLEN-1:0] BOOT_ADDRESS = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // ALU_PASS_B serves LUI, ALU_ADD_PC serves AUIPC (pc + imm).
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;
  localparam logic [3:0] ALU_ADD_PC = 4'd11;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_op;
    logic [2:0]        funct3;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        wb_sel;
    logic              illegal;
  } id_ex_t;

  // Bit 30 selects SUB only for register-register ops, but SRA/SRAI for both.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3,
                                                input logic       alt,
                                                input logic       is_reg);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stage_2_reg_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one write port, x0 hard-wired to zero.
module stage_2_reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0)                 rd_data_a = '0;
    else if (we && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0)                 rd_data_b = '0;
    else if (we && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end

endmodule

// File: rtl/stage_2.sv
// RV32I decode stage: register read, immediate/control decode, load-use
// stall with an internal hold slot, and flush on a taken branch from EX.
module stage_2
  import stage_2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic [31:0]       if_id_instr,
  input  logic              b_taken,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [XLEN-1:0]   id_ex_rs1_val,
  output logic [XLEN-1:0]   id_ex_rs2_val,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [REG_AW-1:0] id_ex_rs1,
  output logic [REG_AW-1:0] id_ex_rs2,
  output logic [REG_AW-1:0] id_ex_rd,
  output logic [3:0]        id_ex_alu_op,
  output logic [2:0]        id_ex_funct3,
  output logic              id_ex_alu_src,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_read,
  output logic              id_ex_mem_write,
  output logic              id_ex_branch,
  output logic              id_ex_jump,
  output logic [1:0]        id_ex_wb_sel,
  output logic              id_ex_illegal
);

  id_ex_t            id_ex_q;
  id_ex_t            dec_next;
  logic              hold_valid;
  logic [XLEN-1:0]   hold_pc;
  logic [31:0]       hold_instr;

  logic [XLEN-1:0]   src_pc;
  logic [31:0]       src_instr;
  logic [6:0]        opcode;

  imm_fmt_e          fmt;
  logic              valid;
  logic              illegal;
  logic              rs1_used;
  logic              rs2_used;
  logic              rd_used;
  logic [3:0]        alu_op;
  logic              alu_src;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic [1:0]        wb_sel;
  logic [XLEN-1:0]   imm;

  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;

  // Fetch emits a bubble while stalled, so the stalled instruction is replayed from here.
  assign src_pc    = hold_valid ? hold_pc : if_id_pc;
  assign src_instr = hold_valid ? hold_instr : if_id_instr;
  assign opcode    = src_instr[6:0];

  always_comb begin
    fmt       = FMT_NONE;
    valid     = 1'b0;
    illegal   = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    rd_used   = 1'b0;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    wb_sel    = WB_SEL_ALU;
    if (src_instr != '0) begin
      valid = 1'b1;
      case (opcode)
        OP_LUI: begin
          fmt = FMT_U; rd_used = 1'b1; reg_write = 1'b1;
          alu_src = 1'b1; alu_op = ALU_PASS_B;
        end
        OP_AUIPC: begin
          fmt = FMT_U; rd_used = 1'b1; reg_write = 1'b1;
          alu_src = 1'b1; alu_op = ALU_ADD_PC;
        end
        OP_JAL: begin
          fmt = FMT_J; rd_used = 1'b1; reg_write = 1'b1;
          alu_src = 1'b1; jump = 1'b1; wb_sel = WB_SEL_PC4;
        end
        OP_JALR: begin
          fmt = FMT_I; rs1_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
          alu_src = 1'b1; jump = 1'b1; wb_sel = WB_SEL_PC4;
        end
        OP_BRANCH: begin
          fmt = FMT_B; rs1_used = 1'b1; rs2_used = 1'b1;
          branch = 1'b1; alu_op = ALU_SUB;
        end
        OP_LOAD: begin
          fmt = FMT_I; rs1_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
          alu_src = 1'b1; mem_read = 1'b1; wb_sel = WB_SEL_MEM;
        end
        OP_STORE: begin
          fmt = FMT_S; rs1_used = 1'b1; rs2_used = 1'b1;
          alu_src = 1'b1; mem_write = 1'b1;
        end
        OP_IMM: begin
          fmt = FMT_I; rs1_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
          alu_src = 1'b1; alu_op = alu_from_funct(src_instr[14:12], src_instr[30], 1'b0);
        end
        OP_OP: begin
          rs1_used = 1'b1; rs2_used = 1'b1; rd_used = 1'b1; reg_write = 1'b1;
          alu_op = alu_from_funct(src_instr[14:12], src_instr[30], 1'b1);
        end
        default: begin
          valid   = 1'b0;
          illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{src_instr[31]}}, src_instr[31:20]};
      FMT_S:   imm = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
      FMT_B:   imm = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                      src_instr[30:25], src_instr[11:8], 1'b0};
      FMT_U:   imm = {src_instr[31:12], 12'b0};
      FMT_J:   imm = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                      src_instr[20], src_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Unused source fields read as x0 so forwarding never matches on them.
  assign rs1_addr = rs1_used ? src_instr[19:15] : '0;
  assign rs2_addr = rs2_used ? src_instr[24:20] : '0;

  stage_2_reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (REG_AW)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we        (wb_we),
    .wr_addr   (wb_rd),
    .wr_data   (wb_data),
    .rd_addr_a (rs1_addr),
    .rd_data_a (rs1_data),
    .rd_addr_b (rs2_addr),
    .rd_data_b (rs2_data)
  );

  always_comb begin
    dec_next = '0;
    if (valid) begin
      dec_next.pc        = src_pc;
      dec_next.rs1_val   = rs1_data;
      dec_next.rs2_val   = rs2_data;
      dec_next.imm       = imm;
      dec_next.rs1       = rs1_addr;
      dec_next.rs2       = rs2_addr;
      dec_next.rd        = rd_used ? src_instr[11:7] : '0;
      dec_next.alu_op    = alu_op;
      dec_next.funct3    = src_instr[14:12];
      dec_next.alu_src   = alu_src;
      dec_next.reg_write = reg_write;
      dec_next.mem_read  = mem_read;
      dec_next.mem_write = mem_write;
      dec_next.branch    = branch;
      dec_next.jump      = jump;
      dec_next.wb_sel    = wb_sel;
    end
    dec_next.illegal = illegal;
  end

  assign stall = id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                 ((rs1_used && (id_ex_q.rd == rs1_addr)) ||
                  (rs2_used && (id_ex_q.rd == rs2_addr))) &&
                 !b_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q    <= '0;
      hold_valid <= 1'b0;
      hold_pc    <= BOOT_ADDRESS;
      hold_instr <= '0;
    end else if (b_taken) begin
      id_ex_q    <= '0;
      hold_valid <= 1'b0;
    end else if (stall) begin
      id_ex_q    <= '0;
      hold_pc    <= src_pc;
      hold_instr <= src_instr;
      hold_valid <= 1'b1;
    end else begin
      id_ex_q    <= dec_next;
      hold_valid <= 1'b0;
    end
  end

  assign id_ex_pc        = id_ex_q.pc;
  assign id_ex_rs1_val   = id_ex_q.rs1_val;
  assign id_ex_rs2_val   = id_ex_q.rs2_val;
  assign id_ex_imm       = id_ex_q.imm;
  assign id_ex_rs1       = id_ex_q.rs1;
  assign id_ex_rs2       = id_ex_q.rs2;
  assign id_ex_rd        = id_ex_q.rd;
  assign id_ex_alu_op    = id_ex_q.alu_op;
  assign id_ex_funct3    = id_ex_q.funct3;
  assign id_ex_alu_src   = id_ex_q.alu_src;
  assign id_ex_reg_write = id_ex_q.reg_write;
  assign id_ex_mem_read  = id_ex_q.mem_read;
  assign id_ex_mem_write = id_ex_q.mem_write;
  assign id_ex_branch    = id_ex_q.branch;
  assign id_ex_jump      = id_ex_q.jump;
  assign id_ex_wb_sel    = id_ex_q.wb_sel;
  assign id_ex_illegal   = id_ex_q.illegal;

endmodule

// File: doc/stage_2.md
Name: stage_2

Overview:
- RV32I decode stage. Sits between fetch (stage_1: if_id_pc/if_id_instr) and execute.
- Reads the 32x32 register file, generates the immediate and control signals, and loads the ID/EX pipeline register.
- Detects load-use hazards and drives the fetch-stage stall. Holds the stalled instruction internally, because fetch emits a bubble while stalled.
- Flushes on a taken branch from EX.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count (x0 hard-wired zero)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_id_pc  in  32  PC of the instruction from fetch
- if_id_instr  in  32  instruction from fetch; 0 = bubble
- b_taken  in  1  EX resolved a taken branch/jump this cycle
- wb_we  in  1  writeback enable from WB
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- stall  out  1  combinational; to stage_1 stall input
- id_ex_pc  out  32  registered PC
- id_ex_rs1_val, id_ex_rs2_val  out  32 each  register operands
- id_ex_imm  out  32  sign-extended immediate
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  register indices (for forwarding)
- id_ex_alu_op  out  4  ALU operation code (encodings in constants.vh)
- id_ex_funct3  out  3  funct3 pass-through (branch/load/store width)
- id_ex_alu_src  out  1  1 = imm as operand B
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch, id_ex_jump  out  1 each
- id_ex_wb_sel  out  2  0 ALU, 1 mem, 2 PC+4
- id_ex_illegal  out  1  undefined opcode decoded

Behaviour:
- Reset (async, rst=1): all id_ex_* = 0 (NOP bubble), all registers = 0, hold_valid = 0, stall = 0. Reset mid-stall discards the held instruction.
- Decode source: if hold_valid then hold_pc/hold_instr, else if_id_pc/if_id_instr.
- Register file:
  - Write on posedge when wb_we=1 and wb_rd!=0.
  - Reads are combinational, with write-through bypass: if wb_we and wb_rd==rsX and rsX!=0, read returns wb_data.
  - x0 always reads 0.
- Immediates: I/S/B/U/J formats per RV32I, sign-extended from bit 31. B/J have LSB 0.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- rs1/rs2 "used" flags are per-format: U/J use neither; I uses rs1 only.
- Instr 0 decodes as a bubble: all controls 0, no hazard check.
- Any other opcode: bubble controls plus id_ex_illegal=1 for one cycle.
- Hazard (combinational): stall = id_ex_mem_read & (id_ex_rd!=0) & ((rs1_used & id_ex_rd==rs1) | (rs2_used & id_ex_rd==rs2)) & !b_taken.
- Posedge priority, highest first:
  1. b_taken=1: ID/EX <= bubble; hold_valid <= 0.
  2. stall=1: ID/EX <= bubble; hold_pc/hold_instr <= current decode source; hold_valid <= 1.
  3. Otherwise: ID/EX <= decoded values; hold_valid <= 0.
- Load-use latency: exactly 1 bubble cycle. The held instruction issues the cycle after stall. The if_id bubble arriving during the hold cycle is ignored.
- Bubble means every id_ex_* output = 0, including pc and indices.

Decomposition:
- constants.vh (shared):
  - opcode localparams (OP_LUI=7'b0110111, ...)
  - ALU_* op codes
  - WB_SEL_* codes
  - BOOT_ADDRESS
- Sub-module reg_file: 2 read ports, 1 write port, bypass, x0 zero. Reset is async, same rst.
- Immediate generator and control decoder stay inline as combinational blocks.

Test Plan:
1. Reset, then wb_we=1 wb_rd=1 wb_data=5, next cycle if_id_instr=0x00008113 (addi x2,x1,0) -> id_ex_rs1_val=5, id_ex_imm=0, id_ex_alu_src=1, id_ex_rd=2, id_ex_reg_write=1.
2. Same-cycle write/read: wb_rd=1 wb_data=0xDEADBEEF while decoding 0x001081B3 (add x3,x1,x1) -> id_ex_rs1_val=id_ex_rs2_val=0xDEADBEEF. wb_rd=0 wb_data=7 with a read of x0 -> 0.
3. Load-use:
   - Stimulus: 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 (add x3,x2,x1).
   - Response: stall=1 for exactly one cycle; ID/EX holds a bubble.
   - Next cycle: id_ex_rd=3 with the correct pc, while if_id_instr=0 during the hold.
4. Taken branch: b_taken=1 while decoding 0x00500093 -> ID/EX bubble (id_ex_reg_write=0, id_ex_pc=0). b_taken=1 coinciding with a load-use hazard -> stall=0, hold cleared.
5. Immediates:
   - 0xFE000EE3 (beq x0,x0,-4) -> id_ex_imm=0xFFFFFFFC, branch=1.
   - 0x123450B7 (lui) -> imm=0x12345000.
   - 0x0000006F-class JAL -> wb_sel=2, jump=1.
6. Illegal opcode 0x0000007F -> id_ex_illegal=1, all other controls 0. Assert rst mid-hold -> all outputs 0 immediately, hold_valid=0.
